// File: rtl/optical_flow_frame_scheduler_if.sv
// AXI4-Stream video link: tuser marks start of frame, tlast marks end of line.
interface optical_flow_frame_scheduler_if #(
    parameter int unsigned DATA_BITS = 10
);
    logic                 tuser;
    logic                 tlast;
    logic [DATA_BITS-1:0] tdata;
    logic                 tvalid;
    logic                 tready;

    modport master (
        output tuser, tlast, tdata, tvalid,
        input  tready
    );

    modport slave (
        input  tuser, tlast, tdata, tvalid,
        output tready
    );
endinterface

// File: rtl/optical_flow_frame_scheduler.sv
// Frame-level scheduler between the camera stream and the optical-flow /
// write-DMA path. Passes or discards whole frames depending on enable,
// one-shot mode, decimation and DMA availability, and keeps status counters.
module optical_flow_frame_scheduler #(
    parameter int unsigned DATA_BITS    = 10,
    parameter int unsigned HEIGHT_BITS  = 16,
    parameter int unsigned SKIP_BITS    = 8,
    parameter int unsigned TIMEOUT_BITS = 24,
    parameter int unsigned COUNT_BITS   = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic                    ctl_enable,
    input  logic                    ctl_oneshot,
    input  logic [SKIP_BITS-1:0]    ctl_skip,
    input  logic [TIMEOUT_BITS-1:0] ctl_timeout,
    input  logic [HEIGHT_BITS-1:0]  param_height,

    optical_flow_frame_scheduler_if.slave  s_axi4s,
    optical_flow_frame_scheduler_if.master m_axi4s,

    output logic                    dma_start,
    input  logic                    dma_busy,

    output logic                    stat_busy,
    output logic [COUNT_BITS-1:0]   stat_frame_count,
    output logic [COUNT_BITS-1:0]   stat_drop_count,
    output logic                    stat_timeout,
    output logic                    irq_frame
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PASS     = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    localparam logic [HEIGHT_BITS-1:0]  LINE_ONE  = HEIGHT_BITS'(1);
    localparam logic [TIMEOUT_BITS-1:0] TMO_ONE   = TIMEOUT_BITS'(1);
    localparam logic [SKIP_BITS-1:0]    SKIP_ONE  = SKIP_BITS'(1);
    localparam logic [COUNT_BITS-1:0]   COUNT_ONE = COUNT_BITS'(1);

    state_t                  state_q, state_d;
    logic                    ready_en_q;
    logic                    ctl_enable_q;
    logic [SKIP_BITS-1:0]    skip_cnt_q, skip_cnt_d;
    logic [HEIGHT_BITS-1:0]  line_cnt_q, line_cnt_d;
    logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [COUNT_BITS-1:0]   frame_cnt_q, frame_cnt_d;
    logic [COUNT_BITS-1:0]   drop_cnt_q, drop_cnt_d;
    logic                    timeout_q, timeout_d;

    logic                    enable_rise;
    logic                    take;
    logic                    pass_sel;
    logic                    xfer;
    logic                    sof;
    logic                    eol_xfer;
    logic                    last_line;
    logic                    tmo_hit;
    logic [DATA_BITS-1:0]    pixel;
    state_t                  exit_state;

    // Stream routing: zero-latency pass-through or discard with ready held high.
    always_comb begin
        enable_rise = ctl_enable & ~ctl_enable_q;
        take        = ctl_enable & (skip_cnt_q == '0) & ~dma_busy;
        pass_sel    = (state_q == PASS) |
                      ((state_q == WAIT_SOF) & s_axi4s.tuser & take);
        pixel       = s_axi4s.tdata;

        m_axi4s.tuser  = s_axi4s.tuser;
        m_axi4s.tlast  = s_axi4s.tlast;
        m_axi4s.tdata  = pixel;
        m_axi4s.tvalid = pass_sel & s_axi4s.tvalid;
        s_axi4s.tready = pass_sel ? m_axi4s.tready : ready_en_q;

        xfer       = s_axi4s.tvalid & s_axi4s.tready;
        sof        = xfer & s_axi4s.tuser;
        eol_xfer   = xfer & s_axi4s.tlast;
        last_line  = (line_cnt_q == (param_height - LINE_ONE));
        tmo_hit    = (ctl_timeout != '0) && (tmo_cnt_q == (ctl_timeout - TMO_ONE));
        exit_state = (ctl_oneshot | ~ctl_enable) ? IDLE : WAIT_SOF;
    end

    // Frame FSM: next state, counters and the single-cycle dma_start/irq pulses.
    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        line_cnt_d  = line_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        timeout_d   = timeout_q;
        dma_start   = 1'b0;
        irq_frame   = 1'b0;

        // A new enable edge clears the sticky flag in any state; a timeout
        // detected in the same cycle still sets it below.
        if (enable_rise) begin
            timeout_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (ctl_enable & (~ctl_oneshot | enable_rise)) begin
                    state_d    = WAIT_SOF;
                    skip_cnt_d = '0;
                end
            end
            WAIT_SOF: begin
                if (!ctl_enable) begin
                    state_d = IDLE;
                end else if (sof) begin
                    if (take) begin
                        dma_start  = 1'b1;
                        skip_cnt_d = ctl_skip;
                        line_cnt_d = '0;
                        tmo_cnt_d  = '0;
                        state_d    = PASS;
                    end else if (skip_cnt_q != '0) begin
                        skip_cnt_d = skip_cnt_q - SKIP_ONE;
                    end else begin
                        drop_cnt_d = drop_cnt_q + COUNT_ONE;
                    end
                end
            end
            PASS: begin
                tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                if (eol_xfer) begin
                    line_cnt_d = line_cnt_q + LINE_ONE;
                end
                // Frame end has priority over a timeout in the same cycle.
                if (eol_xfer & last_line) begin
                    state_d = DRAIN;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = exit_state;
                end
            end
            DRAIN: begin
                tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                if (!dma_busy) begin
                    irq_frame   = 1'b1;
                    frame_cnt_d = frame_cnt_q + COUNT_ONE;
                    state_d     = exit_state;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = exit_state;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; ready_en rises one cycle after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            ready_en_q   <= 1'b0;
            ctl_enable_q <= 1'b0;
            skip_cnt_q   <= '0;
            line_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_en_q   <= 1'b1;
            ctl_enable_q <= ctl_enable;
            skip_cnt_q   <= skip_cnt_d;
            line_cnt_q   <= line_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign stat_busy        = (state_q != IDLE);
    assign stat_frame_count = frame_cnt_q;
    assign stat_drop_count  = drop_cnt_q;
    assign stat_timeout     = timeout_q;

endmodule

// File: tb/tb_optical_flow_frame_scheduler.sv
// Directed bench for optical_flow_frame_scheduler: a table of frame scenarios
// plus hand-written reset sequences, with a sink scoreboard and a DMA model.
module tb_optical_flow_frame_scheduler;

    localparam int W       = 8;   // pixels per line
    localparam int HB      = 2;   // horizontal blank cycles
    localparam int VB      = 50;  // vertical blank cycles
    localparam int DMA_LEN = 50;  // DMA busy cycles after start

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ctl_enable = 1'b0;
    logic        ctl_oneshot = 1'b0;
    logic [7:0]  ctl_skip = '0;
    logic [23:0] ctl_timeout = '0;
    logic [15:0] param_height = 16'd4;
    logic        dma_start;
    logic        dma_busy;
    logic        stat_busy;
    logic [31:0] stat_frame_count;
    logic [31:0] stat_drop_count;
    logic        stat_timeout;
    logic        irq_frame;

    logic        force_busy = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        mon_start = 1'b0;
    int          dma_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_irq    = 0;
    int exp_frame_tot = 0;
    int exp_drop_tot  = 0;
    int fid = 0;

    typedef struct packed {
        logic       u;
        logic       l;
        logic [9:0] d;
    } beat_t;

    beat_t exp_q[$];

    typedef struct {
        logic        oneshot;
        logic [7:0]  skip;
        logic [15:0] height;
        int          lines;
        logic [23:0] tmo;
        int          nframes;
        int          busy_frame;
        logic        rnd;
        logic [15:0] pass_mask;
        int          exp_frames;
        int          exp_drops;
        logic        exp_tmo;
        int          exp_irq;
    } scn_t;

    scn_t scn[9];

    optical_flow_frame_scheduler_if #(.DATA_BITS(10)) s_if ();
    optical_flow_frame_scheduler_if #(.DATA_BITS(10)) m_if ();

    assign dma_busy = force_busy | (dma_cnt != 0);

    optical_flow_frame_scheduler #(
        .DATA_BITS   (10),
        .HEIGHT_BITS (16),
        .SKIP_BITS   (8),
        .TIMEOUT_BITS(24),
        .COUNT_BITS  (32)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .ctl_enable      (ctl_enable),
        .ctl_oneshot     (ctl_oneshot),
        .ctl_skip        (ctl_skip),
        .ctl_timeout     (ctl_timeout),
        .param_height    (param_height),
        .s_axi4s         (s_if.slave),
        .m_axi4s         (m_if.master),
        .dma_start       (dma_start),
        .dma_busy        (dma_busy),
        .stat_busy       (stat_busy),
        .stat_frame_count(stat_frame_count),
        .stat_drop_count (stat_drop_count),
        .stat_timeout    (stat_timeout),
        .irq_frame       (irq_frame)
    );

    always #5 aclk = ~aclk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic logic [9:0] pix(input int f, input int l, input int c);
        int v;
        v = f * 40 + l * W + c + 7;
        return v[9:0];
    endfunction

    // Sink scoreboard and pulse counters, sampled on the falling edge.
    task automatic monitor();
        beat_t b;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                mon_start = dma_start;
                if (dma_start) n_start++;
                if (irq_frame) n_irq++;
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sink_unexpected_beat: got data %0d, required no beat (t=%0t)",
                                 m_if.tdata, $time);
                    end else begin
                        b = exp_q.pop_front();
                        chk("sink_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, b);
                    end
                end
            end else begin
                mon_start = 1'b0;
            end
        end
    endtask

    // DMA model and sink ready generator, updated just after the rising edge.
    task automatic drivers();
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn)            dma_cnt = 0;
            else if (mon_start)      dma_cnt = DMA_LEN;
            else if (dma_cnt > 0)    dma_cnt--;
            m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_beat(input beat_t b);
        int g;
        s_if.tuser  = b.u;
        s_if.tlast  = b.l;
        s_if.tdata  = b.d;
        s_if.tvalid = 1'b1;
        g = 0;
        do begin
            @(negedge aclk);
            g++;
        end while (!s_if.tready && g < 300);
        if (!s_if.tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL src_accept: beat not accepted within %0d cycles (t=%0t)", g, $time);
        end
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int lines, input logic passed, input logic busy_sof);
        beat_t b;
        force_busy = busy_sof;
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < W; c++) begin
                b.u = (l == 0) && (c == 0);
                b.l = (c == W - 1);
                b.d = pix(fid, l, c);
                if (passed) exp_q.push_back(b);
                send_beat(b);
                force_busy = 1'b0;
            end
            idle(HB);
        end
        idle(VB);
        fid++;
    endtask

    task automatic run_scn(input scn_t s, input int idx);
        ctl_enable = 1'b0;
        idle(3);
        ctl_oneshot  = s.oneshot;
        ctl_skip     = s.skip;
        param_height = s.height;
        ctl_timeout  = s.tmo;
        rand_rdy     = s.rnd;
        n_start = 0;
        n_irq   = 0;
        ctl_enable = 1'b1;
        idle(3);
        for (int f = 0; f < s.nframes; f++) begin
            send_frame(s.lines, s.pass_mask[f], (f == s.busy_frame));
        end
        idle(40);
        exp_frame_tot += s.exp_frames;
        exp_drop_tot  += s.exp_drops;
        $display("scenario %0d checks", idx);
        chk("sink_all_beats_seen", exp_q.size(), 0);
        chk("frame_count", stat_frame_count, exp_frame_tot);
        chk("drop_count", stat_drop_count, exp_drop_tot);
        chk("timeout_flag", stat_timeout, s.exp_tmo);
        chk("irq_pulses", n_irq, s.exp_irq);
        chk("dma_starts", n_start, $countones(s.pass_mask));
        chk("busy_while_enabled", stat_busy, !s.oneshot);
        exp_q.delete();
        rand_rdy = 1'b0;
        ctl_enable = 1'b0;
        idle(3);
        chk("busy_after_disable", stat_busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        $display("reset checks: %s", tag);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_stat_busy", stat_busy, 0);
        chk("rst_frame_count", stat_frame_count, 0);
        chk("rst_drop_count", stat_drop_count, 0);
        chk("rst_timeout", stat_timeout, 0);
        chk("rst_dma_start", dma_start, 0);
        chk("rst_irq", irq_frame, 0);
    endtask

    task automatic release_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("ready_low_after_release", s_if.tready, 0);
        @(posedge aclk);
        #1;
        chk("ready_high_one_cycle_later", s_if.tready, 1);
        chk("idle_after_release", stat_busy, 0);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        //          os skip h  ln tmo   n  busy rnd mask      frm drp tmo irq
        scn[0] = '{1'b0, 8'd0, 16'd4, 4, 24'd0,    4, -1, 1'b0, 16'h000F, 4, 0, 1'b0, 4}; // continuous
        scn[1] = '{1'b0, 8'd2, 16'd4, 4, 24'd0,    9, -1, 1'b0, 16'h0049, 3, 0, 1'b0, 3}; // decimation
        scn[2] = '{1'b0, 8'd0, 16'd4, 4, 24'd0,    3,  1, 1'b0, 16'h0005, 2, 1, 1'b0, 2}; // DMA contention
        scn[3] = '{1'b0, 8'd0, 16'd4, 4, 24'd0,    3, -1, 1'b1, 16'h0007, 3, 0, 1'b0, 3}; // backpressure
        scn[4] = '{1'b1, 8'd0, 16'd4, 4, 24'd0,    3, -1, 1'b0, 16'h0001, 1, 0, 1'b0, 1}; // one-shot
        scn[5] = '{1'b0, 8'd0, 16'd6, 4, 24'd55,   2, -1, 1'b0, 16'h0003, 0, 0, 1'b1, 0}; // timeout
        scn[6] = '{1'b1, 8'd0, 16'd4, 4, 24'd0,    2, -1, 1'b0, 16'h0001, 1, 0, 1'b0, 1}; // second one-shot, flag cleared
        scn[7] = '{1'b0, 8'd0, 16'd4, 4, 24'd1000, 2, -1, 1'b0, 16'h0003, 2, 0, 1'b0, 2}; // timeout armed, not reached
        scn[8] = '{1'b0, 8'd1, 16'd1, 1, 24'd0,    4, -1, 1'b0, 16'h0005, 2, 0, 1'b0, 2}; // single-line frames, skip 1

        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;

        fork
            monitor();
            drivers();
        join_none

        #23;
        check_reset_outputs("power-on");
        release_reset();

        for (int i = 0; i < 9; i++) begin
            run_scn(scn[i], i);
        end

        // Reset asserted in the middle of a passed frame.
        ctl_oneshot  = 1'b0;
        ctl_skip     = '0;
        param_height = 16'd4;
        ctl_timeout  = '0;
        ctl_enable   = 1'b1;
        idle(3);
        for (int k = 0; k < W + 3; k++) begin
            b.u = (k == 0);
            b.l = (k == W - 1);
            b.d = pix(fid, k / W, k % W);
            exp_q.push_back(b);
            send_beat(b);
        end
        chk("midframe_busy", stat_busy, 1);
        chk("midframe_fwd_beats_seen", exp_q.size(), 0);
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = pix(fid, 1, 3);
        s_if.tvalid = 1'b1;
        chk("midframe_tvalid_before_reset", m_if.tvalid, 1);
        aresetn = 1'b0;
        ctl_enable = 1'b0;
        #1;
        check_reset_outputs("mid-frame");
        s_if.tvalid = 1'b0;
        exp_q.delete();
        exp_frame_tot = 0;
        exp_drop_tot  = 0;
        fid++;
        idle(3);
        release_reset();
        idle(3);
        chk("idle_holds_with_enable_low", stat_busy, 0);

        // Recovery after reset: continuous capture from clean counters.
        run_scn(scn[0], 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
